mem_stage: RTL and testbench

Memory-access stage directly downstream of the execute stage. Accepts the ALU result, the store operand and the link address (PC+4) from execute, and performs loads and stores over a req/ack data-memory bus. It formats load data with byte-lane selection and sign/zero extension, picks the write-back value, and presents one registered result per instruction to write-back. It back-pressures execute with ready_o while a bus transaction is outstanding.

---
 rtl/mem_stage.sv | 279 +++++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: formats loads/stores onto a req/ack data bus and returns one registered
// write-back result per instruction; ready_o stays low while a bus access is outstanding.
module mem_stage #(
  parameter int unsigned BUS_TIMEOUT = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        flush_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] pc_plus4_i,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [2:0]  mem_op_i,
  input  logic [1:0]  wb_sel_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        reg_wr_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        valid_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  rd_addr_o,
  output logic        reg_wr_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic {S_IDLE, S_WAIT_ACK} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  size_t       size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  wb_sel_q, wb_sel_d;
  logic [4:0]  rd_q, rd_d;
  logic        reg_wr_q, reg_wr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        flush_q, flush_d;
  logic [31:0] tmr_q, tmr_d;

  logic        valid_q, valid_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  rd_out_q, rd_out_d;
  logic        reg_wr_out_q, reg_wr_out_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;

  logic        accept;
  logic        is_mem;
  logic        misaligned;
  logic        timeout;
  logic        kill;
  size_t       size_in;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] lane;
  logic [31:0] ld_data;

  function automatic logic [31:0] sel_wb(input logic [1:0]  sel,
                                         input logic [31:0] alu,
                                         input logic [31:0] ld,
                                         input logic [31:0] pc4);
    case (sel)
      2'b01:   return ld;
      2'b10:   return pc4;
      default: return alu;
    endcase
  endfunction

  assign accept = valid_i && (state_q == S_IDLE) && !flush_i;
  assign is_mem = mem_rd_i || mem_wr_i;
  assign kill   = flush_q || flush_i;

  // Unsupported funct3 encodings fall through to word accesses.
  always_comb begin
    case (mem_op_i)
      3'b000, 3'b100: size_in = SZ_B;
      3'b001, 3'b101: size_in = SZ_H;
      default:        size_in = SZ_W;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    case (size_in)
      SZ_H:    misaligned = alu_result_i[0];
      SZ_W:    misaligned = (alu_result_i[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    st_wdata = rs2_i;
    st_be    = 4'b1111;
    if (mem_wr_i) begin
      case (size_in)
        SZ_B: begin
          st_wdata = {4{rs2_i[7:0]}};
          st_be    = 4'b0001 << alu_result_i[1:0];
        end
        SZ_H: begin
          st_wdata = {2{rs2_i[15:0]}};
          st_be    = 4'b0011 << alu_result_i[1:0];
        end
        default: begin
          st_wdata = rs2_i;
          st_be    = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    lane    = dmem_rdata_i >> {addr_q[1:0], 3'b000};
    ld_data = dmem_rdata_i;
    case (size_q)
      SZ_B:    ld_data = uns_q ? {24'd0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      SZ_H:    ld_data = uns_q ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: ld_data = dmem_rdata_i;
    endcase
  end

  // Counter is zeroed on accept, so expiry lands exactly BUS_TIMEOUT cycles after req rises.
  always_comb begin
    timeout = 1'b0;
    if (BUS_TIMEOUT != 0) begin
      timeout = (tmr_q == BUS_TIMEOUT - 1);
    end
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    size_d       = size_q;
    uns_d        = uns_q;
    wb_sel_d     = wb_sel_q;
    rd_d         = rd_q;
    reg_wr_d     = reg_wr_q;
    pc4_d        = pc4_q;
    flush_d      = flush_q;
    tmr_d        = tmr_q;
    valid_d      = 1'b0;
    wb_data_d    = wb_data_q;
    rd_out_d     = rd_out_q;
    reg_wr_out_d = 1'b0;
    misalign_d   = 1'b0;
    bus_err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            valid_d      = 1'b1;
            wb_data_d    = sel_wb(wb_sel_i, alu_result_i, alu_result_i, pc_plus4_i);
            rd_out_d     = rd_addr_i;
            reg_wr_out_d = reg_wr_i;
          end else if (misaligned) begin
            valid_d      = 1'b1;
            misalign_d   = 1'b1;
            wb_data_d    = alu_result_i;
            rd_out_d     = rd_addr_i;
          end else begin
            state_d  = S_WAIT_ACK;
            req_d    = 1'b1;
            we_d     = mem_wr_i;
            addr_d   = alu_result_i;
            wdata_d  = st_wdata;
            be_d     = st_be;
            size_d   = size_in;
            uns_d    = mem_op_i[2];
            wb_sel_d = wb_sel_i;
            rd_d     = rd_addr_i;
            reg_wr_d = reg_wr_i && !mem_wr_i;
            pc4_d    = pc_plus4_i;
            flush_d  = 1'b0;
            tmr_d    = 32'd0;
          end
        end
      end

      S_WAIT_ACK: begin
        flush_d = kill;
        if (dmem_ack_i || timeout) begin
          state_d  = S_IDLE;
          req_d    = 1'b0;
          valid_d  = !kill;
          rd_out_d = rd_q;
          if (dmem_ack_i) begin
            wb_data_d    = sel_wb(wb_sel_q, addr_q, ld_data, pc4_q);
            reg_wr_out_d = reg_wr_q && !kill;
          end else begin
            wb_data_d = addr_q;
            bus_err_d = !kill;
          end
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      be_q         <= 4'd0;
      size_q       <= SZ_W;
      uns_q        <= 1'b0;
      wb_sel_q     <= 2'd0;
      rd_q         <= 5'd0;
      reg_wr_q     <= 1'b0;
      pc4_q        <= 32'd0;
      flush_q      <= 1'b0;
      tmr_q        <= 32'd0;
      valid_q      <= 1'b0;
      wb_data_q    <= 32'd0;
      rd_out_q     <= 5'd0;
      reg_wr_out_q <= 1'b0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      wb_sel_q     <= wb_sel_d;
      rd_q         <= rd_d;
      reg_wr_q     <= reg_wr_d;
      pc4_q        <= pc4_d;
      flush_q      <= flush_d;
      tmr_q        <= tmr_d;
      valid_q      <= valid_d;
      wb_data_q    <= wb_data_d;
      rd_out_q     <= rd_out_d;
      reg_wr_out_q <= reg_wr_out_d;
      misalign_q   <= misalign_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign ready_o      = (state_q == S_IDLE);
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = {addr_q[31:2], 2'b00};
  assign dmem_wdata_o = wdata_q;
  assign dmem_be_o    = be_q;
  assign valid_o      = valid_q;
  assign wb_data_o    = wb_data_q;
  assign rd_addr_o    = rd_out_q;
  assign reg_wr_o     = reg_wr_out_q;
  assign misalign_o   = misalign_q;
  assign bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: a bus responder with random ack delay, checked against a
// per-instruction reference model built from access size, alignment and lane arithmetic.
module tb_mem_stage;
  localparam int TMO = 4;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        valid_i, ready_o, flush_i;
  logic [31:0] alu_result_i, rs2_i, pc_plus4_i;
  logic        mem_rd_i, mem_wr_i;
  logic [2:0]  mem_op_i;
  logic [1:0]  wb_sel_i;
  logic [4:0]  rd_addr_i;
  logic        reg_wr_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        valid_o;
  logic [31:0] wb_data_o;
  logic [4:0]  rd_addr_o;
  logic        reg_wr_o, misalign_o, bus_err_o;

  mem_stage #(.BUS_TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready_o), .flush_i(flush_i),
    .alu_result_i(alu_result_i), .rs2_i(rs2_i), .pc_plus4_i(pc_plus4_i),
    .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i), .mem_op_i(mem_op_i), .wb_sel_i(wb_sel_i),
    .rd_addr_i(rd_addr_i), .reg_wr_i(reg_wr_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o), .dmem_ack_i(dmem_ack_i),
    .dmem_rdata_i(dmem_rdata_i), .valid_o(valid_o), .wb_data_o(wb_data_o),
    .rd_addr_o(rd_addr_o), .reg_wr_o(reg_wr_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int sz_bytes(input logic [2:0] op);
    case (op)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [31:0] ld_fmt(input logic [31:0] rdata, input logic [1:0] off,
                                         input logic [2:0] op);
    int nb;
    logic [31:0] mask, v;
    nb = sz_bytes(op);
    if (nb == 4) return rdata;
    mask = (32'd1 << (8 * nb)) - 32'd1;
    v = (rdata >> (8 * off)) & mask;
    if (!op[2] && v[8 * nb - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic run_instr(input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] pc4,
                           input logic [31:0] rdata, input logic rd_en, input logic wr_en,
                           input logic [2:0] op, input logic [1:0] sel, input logic [4:0] rd,
                           input logic rw, input int dly, input int flush_at, input logic idle_flush);
    int nb;
    logic mem, aligned, acked, flushed;
    logic [31:0] exp_wb;
    nb      = sz_bytes(op);
    mem     = rd_en || wr_en;
    aligned = ((alu & (nb - 1)) == 0);
    check("ready_idle", ready_o, 1);
    valid_i = 1'b1; flush_i = idle_flush;
    alu_result_i = alu; rs2_i = rs2; pc_plus4_i = pc4;
    mem_rd_i = rd_en; mem_wr_i = wr_en; mem_op_i = op; wb_sel_i = sel;
    rd_addr_i = rd; reg_wr_i = rw;
    if (!mem) dmem_ack_i = 1'($urandom_range(0, 1));
    @(negedge clk_i);
    valid_i = 1'b0; flush_i = 1'b0; dmem_ack_i = 1'b0;
    if (idle_flush) begin
      check("idle_flush_valid", valid_o, 0);
      check("idle_flush_req", dmem_req_o, 0);
    end else if (!mem) begin
      exp_wb = (sel == 2'b10) ? pc4 : alu;
      check("alu_valid", valid_o, 1);
      check("alu_wb", wb_data_o, exp_wb);
      check("alu_rd", rd_addr_o, rd);
      check("alu_regwr", reg_wr_o, rw);
      check("alu_misalign", misalign_o, 0);
      check("alu_noreq", dmem_req_o, 0);
    end else if (!aligned) begin
      check("mis_valid", valid_o, 1);
      check("mis_flag", misalign_o, 1);
      check("mis_regwr", reg_wr_o, 0);
      check("mis_wb", wb_data_o, alu);
      check("mis_rd", rd_addr_o, rd);
      check("mis_noreq", dmem_req_o, 0);
    end else begin
      check("req_we", dmem_we_o, wr_en);
      check("req_be", dmem_be_o, wr_en ? (((1 << nb) - 1) << alu[1:0]) : 15);
      if (wr_en) check("req_wdata", dmem_wdata_o, (nb == 1) ? rs2[7:0] * 32'h0101_0101 :
                                                  (nb == 2) ? rs2[15:0] * 32'h0001_0001 : rs2);
      check("req_ready_low", ready_o, 0);
      check("req_no_valid", valid_o, 0);
      acked = 1'b0; flushed = 1'b0;
      for (int c = 1; c <= TMO; c++) begin
        check("req_held", dmem_req_o, 1);
        check("req_addr", dmem_addr_o, alu & 32'hFFFF_FFFC);
        if (c == dly) begin dmem_ack_i = 1'b1; dmem_rdata_i = rdata; end
        if (c == flush_at) begin flush_i = 1'b1; flushed = 1'b1; end
        @(negedge clk_i);
        dmem_ack_i = 1'b0; flush_i = 1'b0; dmem_rdata_i = $urandom;
        if (c == dly) begin acked = 1'b1; break; end
      end
      check("done_req_drop", dmem_req_o, 0);
      check("done_valid", valid_o, !flushed);
      if (!flushed) begin
        check("done_bus_err", bus_err_o, !acked);
        check("done_misalign", misalign_o, 0);
        check("done_rd", rd_addr_o, rd);
        check("done_regwr", reg_wr_o, acked && !wr_en && rw);
        if (acked) begin
          exp_wb = (sel == 2'b01) ? ld_fmt(rdata, alu[1:0], op) : (sel == 2'b10) ? pc4 : alu;
          check("done_wb", wb_data_o, exp_wb);
        end
      end else begin
        check("flushed_regwr", reg_wr_o, 0);
        check("flushed_bus_err", bus_err_o, 0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sel;
    logic [31:0] a;
    int kind;
    rst_n_i = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
    alu_result_i = '0; rs2_i = '0; pc_plus4_i = '0;
    mem_rd_i = 1'b0; mem_wr_i = 1'b0; mem_op_i = '0; wb_sel_i = '0;
    rd_addr_i = '0; reg_wr_i = 1'b0; dmem_ack_i = 1'b0; dmem_rdata_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst_ready", ready_o, 1);
    check("rst_req", dmem_req_o, 0);
    check("rst_we", dmem_we_o, 0);
    check("rst_be", dmem_be_o, 0);
    check("rst_addr", dmem_addr_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_wb", wb_data_o, 0);
    check("rst_regwr", reg_wr_o, 0);
    check("rst_errs", {misalign_o, bus_err_o}, 0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    run_instr(32'h0000_1234, 0, 32'h44, 0, 0, 0, 3'b000, 2'b00, 5'd5, 1, 0, 0, 0);
    check("dir_alu_wb", wb_data_o, 32'h0000_1234);
    run_instr(32'h0000_0103, 0, 0, 32'h80FF_FF7F, 1, 0, 3'b000, 2'b01, 5'd7, 1, 3, 0, 0);
    check("dir_lb_wb", wb_data_o, 32'hFFFF_FF80);
    run_instr(32'h0000_0103, 0, 0, 32'h80FF_FF7F, 1, 0, 3'b100, 2'b01, 5'd7, 1, 3, 0, 0);
    check("dir_lbu_wb", wb_data_o, 32'h0000_0080);
    run_instr(32'h0000_0202, 32'hDEAD_BEEF, 0, 0, 0, 1, 3'b001, 2'b00, 5'd9, 1, 2, 0, 0);
    check("dir_sh_regwr", reg_wr_o, 0);
    run_instr(32'h0000_0301, 0, 0, 0, 1, 0, 3'b010, 2'b01, 5'd3, 1, 1, 0, 0);
    check("dir_lw_mis", misalign_o, 1);
    run_instr(32'h0000_0400, 0, 0, 0, 1, 0, 3'b010, 2'b01, 5'd4, 1, 99, 0, 0);
    check("dir_timeout_err", bus_err_o, 1);
    run_instr(32'h0000_0404, 0, 0, 32'h1234_5678, 1, 0, 3'b010, 2'b01, 5'd4, 1, 3, 2, 0);
    check("dir_flush_wait", valid_o, 0);
    run_instr(32'h0000_0408, 0, 0, 32'hCAFE_F00D, 1, 0, 3'b010, 2'b01, 5'd6, 1, TMO, 0, 0);
    check("dir_ack_at_expiry", wb_data_o, 32'hCAFE_F00D);
    run_instr(32'h0000_0010, 0, 0, 0, 0, 0, 3'b000, 2'b00, 5'd2, 1, 0, 0, 1);

    // Reset asserted in the middle of an outstanding load.
    valid_i = 1'b1; alu_result_i = 32'h0000_0500; mem_rd_i = 1'b1; mem_wr_i = 1'b0;
    mem_op_i = 3'b010; wb_sel_i = 2'b01; rd_addr_i = 5'd8; reg_wr_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0; mem_rd_i = 1'b0;
    check("mid_req_up", dmem_req_o, 1);
    #2 rst_n_i = 1'b0;
    #1;
    check("mid_rst_req", dmem_req_o, 0);
    check("mid_rst_ready", ready_o, 1);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("post_rst_valid", valid_o, 0);
      check("post_rst_req", dmem_req_o, 0);
    end

    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 2);
      a = $urandom;
      sel = 2'($urandom_range(0, 3));
      if (kind != 1 && sel == 2'b01) sel = 2'b10;
      run_instr(a, $urandom, $urandom, $urandom, kind == 1, kind == 2,
                3'($urandom_range(0, 7)), sel, 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)), $urandom_range(1, 6), $urandom_range(0, 12),
                ($urandom_range(0, 9) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
